// File: rtl/mc_cpu_ctrl.sv
// Multi-cycle MIPS control sequencer: Moore FSM driving the shared datapath,
// with memory wait timeout, sticky fault flags and performance counters.
module mc_cpu_ctrl #(
  parameter int CNT_W   = 32,
  parameter int TIMEOUT = 15,
  parameter bit EN_ADDI = 1'b1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             run,
  input  logic [5:0]       opcode,
  input  logic             mem_ready,
  output logic             mem_req,
  output logic             mem_we,
  output logic             iord,
  output logic             ir_write,
  output logic             pc_write,
  output logic             pc_write_cond,
  output logic [1:0]       pc_src,
  output logic             alu_src_a,
  output logic [1:0]       alu_src_b,
  output logic [1:0]       alu_op,
  output logic             reg_dst,
  output logic             reg_write,
  output logic             mem_to_reg,
  output logic [3:0]       state,
  output logic             illegal,
  output logic             timeout,
  output logic [CNT_W-1:0] instr_count,
  output logic [CNT_W-1:0] cycle_count
);

  typedef enum logic [3:0] {
    S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD  = 4'd3,
    S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB  = 4'd7,
    S_BRANCH = 4'd8,  S_JUMP   = 4'd9,  S_ADDIEX = 4'd10, S_ADDIWB = 4'd11,
    S_HALT   = 4'd15
  } state_t;

  localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT - 1);

  state_t           state_q, state_d;
  logic [7:0]       wait_q, wait_d;
  logic             illegal_q, illegal_d;
  logic             timeout_q, timeout_d;
  logic [CNT_W-1:0] icnt_q, icnt_d;
  logic [CNT_W-1:0] ccnt_q, ccnt_d;
  logic             init_q, init_d;
  logic             retire;

  always_comb begin
    state_d       = state_q;
    wait_d        = wait_q;
    illegal_d     = illegal_q;
    timeout_d     = timeout_q;
    icnt_d        = icnt_q;
    ccnt_d        = ccnt_q;
    init_d        = 1'b0;
    retire        = 1'b0;
    mem_req       = 1'b0;
    mem_we        = 1'b0;
    iord          = 1'b0;
    ir_write      = 1'b0;
    pc_write      = 1'b0;
    pc_write_cond = 1'b0;
    pc_src        = 2'd0;
    alu_src_a     = 1'b0;
    alu_src_b     = 2'd0;
    alu_op        = 2'd0;
    reg_dst       = 1'b0;
    reg_write     = 1'b0;
    mem_to_reg    = 1'b0;

    if (run && state_q != S_HALT) ccnt_d = ccnt_q + CNT_W'(1);

    // The first cycle out of reset is a quiet cycle: no outputs, no transition.
    if (reset && !init_q) begin
      unique case (state_q)
        S_FETCH: if (run) begin
          mem_req   = 1'b1;
          alu_src_b = 2'd1;
          if (mem_ready) begin
            ir_write = 1'b1;
            pc_write = 1'b1;
            state_d  = S_DECODE;
          end
        end
        S_DECODE: begin
          alu_src_b = 2'd3;
          case (opcode)
            6'h23, 6'h2B: state_d = S_MEMADR;
            6'h00:        state_d = S_EXEC;
            6'h04:        state_d = S_BRANCH;
            6'h02:        state_d = S_JUMP;
            6'h08: begin
              if (EN_ADDI) state_d = S_ADDIEX;
              else begin
                illegal_d = 1'b1;
                state_d   = S_FETCH;
              end
            end
            default: begin
              illegal_d = 1'b1;
              state_d   = S_FETCH;
            end
          endcase
        end
        S_MEMADR: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_d   = (opcode == 6'h23) ? S_MEMRD : S_MEMWR;
        end
        S_MEMRD: begin
          mem_req = 1'b1;
          iord    = 1'b1;
          if (mem_ready) state_d = S_MEMWB;
        end
        S_MEMWB: begin
          reg_write  = 1'b1;
          mem_to_reg = 1'b1;
          retire     = 1'b1;
          state_d    = S_FETCH;
        end
        S_MEMWR: begin
          mem_req = 1'b1;
          mem_we  = 1'b1;
          iord    = 1'b1;
          if (mem_ready) begin
            retire  = 1'b1;
            state_d = S_FETCH;
          end
        end
        S_EXEC: begin
          alu_src_a = 1'b1;
          alu_op    = 2'd2;
          state_d   = S_ALUWB;
        end
        S_ALUWB: begin
          reg_write = 1'b1;
          reg_dst   = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        S_BRANCH: begin
          alu_src_a     = 1'b1;
          alu_op        = 2'd1;
          pc_write_cond = 1'b1;
          pc_src        = 2'd1;
          retire        = 1'b1;
          state_d       = S_FETCH;
        end
        S_JUMP: begin
          pc_write = 1'b1;
          pc_src   = 2'd2;
          retire   = 1'b1;
          state_d  = S_FETCH;
        end
        S_ADDIEX: begin
          alu_src_a = 1'b1;
          alu_src_b = 2'd2;
          state_d   = S_ADDIWB;
        end
        S_ADDIWB: begin
          reg_write = 1'b1;
          retire    = 1'b1;
          state_d   = S_FETCH;
        end
        default: state_d = S_HALT;
      endcase

      // A ready in the last allowed cycle still completes the access.
      if (mem_req) begin
        if (mem_ready)                wait_d = 8'd0;
        else if (wait_q == WAIT_LAST) begin
          timeout_d = 1'b1;
          state_d   = S_HALT;
        end else                      wait_d = wait_q + 8'd1;
      end
      if (state_d != state_q) wait_d = 8'd0;
      if (retire) icnt_d = icnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q   <= S_FETCH;
      wait_q    <= 8'd0;
      illegal_q <= 1'b0;
      timeout_q <= 1'b0;
      icnt_q    <= '0;
      ccnt_q    <= '0;
      init_q    <= 1'b1;
    end else begin
      state_q   <= state_d;
      wait_q    <= wait_d;
      illegal_q <= illegal_d;
      timeout_q <= timeout_d;
      icnt_q    <= icnt_d;
      ccnt_q    <= ccnt_d;
      init_q    <= init_d;
    end
  end

  assign state       = state_q;
  assign illegal     = illegal_q;
  assign timeout     = timeout_q;
  assign instr_count = icnt_q;
  assign cycle_count = ccnt_q;

endmodule

// File: tb/tb_mc_cpu_ctrl.sv
// Bench for mc_cpu_ctrl: two instances (default build, and 4-bit counters
// without ADDI) driven in lockstep; expected per-cycle states are queued.
module tb_mc_cpu_ctrl;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       run = 1'b0;
  logic [5:0] opcode = 6'h00;
  logic       mem_ready = 1'b0;

  wire [15:0] ctl_a, ctl_b;
  wire [3:0]  state_a, state_b;
  wire        illegal_a, illegal_b, timeout_a, timeout_b;
  wire [31:0] icnt_a, ccnt_a;
  wire [3:0]  icnt_b, ccnt_b;

  int checks = 0;
  int errors = 0;

  typedef struct packed {
    logic [3:0] st;
    logic [5:0] op;
    logic       rdy;
  } ent_t;
  ent_t sb_q[$];

  always #5 clk = ~clk;

  mc_cpu_ctrl #(.CNT_W(32), .TIMEOUT(15), .EN_ADDI(1'b1)) dut_a (
    .clk(clk), .reset(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(ctl_a[15]), .mem_we(ctl_a[14]), .iord(ctl_a[13]), .ir_write(ctl_a[12]),
    .pc_write(ctl_a[11]), .pc_write_cond(ctl_a[10]), .pc_src(ctl_a[9:8]),
    .alu_src_a(ctl_a[7]), .alu_src_b(ctl_a[6:5]), .alu_op(ctl_a[4:3]),
    .reg_dst(ctl_a[2]), .reg_write(ctl_a[1]), .mem_to_reg(ctl_a[0]),
    .state(state_a), .illegal(illegal_a), .timeout(timeout_a),
    .instr_count(icnt_a), .cycle_count(ccnt_a)
  );

  mc_cpu_ctrl #(.CNT_W(4), .TIMEOUT(15), .EN_ADDI(1'b0)) dut_b (
    .clk(clk), .reset(rst), .run(run), .opcode(opcode), .mem_ready(mem_ready),
    .mem_req(ctl_b[15]), .mem_we(ctl_b[14]), .iord(ctl_b[13]), .ir_write(ctl_b[12]),
    .pc_write(ctl_b[11]), .pc_write_cond(ctl_b[10]), .pc_src(ctl_b[9:8]),
    .alu_src_a(ctl_b[7]), .alu_src_b(ctl_b[6:5]), .alu_op(ctl_b[4:3]),
    .reg_dst(ctl_b[2]), .reg_write(ctl_b[1]), .mem_to_reg(ctl_b[0]),
    .state(state_b), .illegal(illegal_b), .timeout(timeout_b),
    .instr_count(icnt_b), .cycle_count(ccnt_b)
  );

  // Control word expected in each state, written from the state table.
  function automatic logic [15:0] exp_ctl(input logic [3:0] s, input logic r, input logic y);
    logic [15:0] c;
    c = '0;
    case (s)
      4'd0:  if (r) begin c[15] = 1'b1; c[6:5] = 2'd1; c[12] = y; c[11] = y; end
      4'd1:  c[6:5] = 2'd3;
      4'd2:  begin c[7] = 1'b1; c[6:5] = 2'd2; end
      4'd3:  begin c[15] = 1'b1; c[13] = 1'b1; end
      4'd4:  begin c[1] = 1'b1; c[0] = 1'b1; end
      4'd5:  begin c[15] = 1'b1; c[14] = 1'b1; c[13] = 1'b1; end
      4'd6:  begin c[7] = 1'b1; c[4:3] = 2'd2; end
      4'd7:  begin c[2] = 1'b1; c[1] = 1'b1; end
      4'd8:  begin c[7] = 1'b1; c[4:3] = 2'd1; c[10] = 1'b1; c[9:8] = 2'd1; end
      4'd9:  begin c[11] = 1'b1; c[9:8] = 2'd2; end
      4'd10: begin c[7] = 1'b1; c[6:5] = 2'd2; end
      4'd11: c[1] = 1'b1;
      default: ;
    endcase
    return c;
  endfunction

  task automatic push(input logic [3:0] st, input logic [5:0] op, input logic rdy);
    ent_t e;
    e.st = st; e.op = op; e.rdy = rdy;
    sb_q.push_back(e);
  endtask

  task automatic push_instr(input logic [5:0] op);
    push(4'd0, op, 1'b1);
    push(4'd1, op, 1'b1);
    case (op)
      6'h23: begin push(4'd2, op, 1'b1); push(4'd3, op, 1'b1); push(4'd4, op, 1'b1); end
      6'h2B: begin push(4'd2, op, 1'b1); push(4'd5, op, 1'b1); end
      6'h00: begin push(4'd6, op, 1'b1); push(4'd7, op, 1'b1); end
      6'h04: push(4'd8, op, 1'b1);
      6'h02: push(4'd9, op, 1'b1);
      6'h08: begin push(4'd10, op, 1'b1); push(4'd11, op, 1'b1); end
      default: ;
    endcase
  endtask

  // Plays the queued cycles with run=1, comparing state and controls each cycle.
  task automatic drain(input bit ca, input bit cb);
    ent_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      run = 1'b1; opcode = e.op; mem_ready = e.rdy;
      #1;
      if (ca) begin
        checks++;
        if (state_a !== e.st || ctl_a !== exp_ctl(e.st, 1'b1, e.rdy)) begin
          errors++;
          $display("FAIL trace_a got st=%0d ctl=%h want st=%0d ctl=%h", state_a, ctl_a, e.st, exp_ctl(e.st, 1'b1, e.rdy));
        end
      end
      if (cb) begin
        checks++;
        if (state_b !== e.st || ctl_b !== exp_ctl(e.st, 1'b1, e.rdy)) begin
          errors++;
          $display("FAIL trace_b got st=%0d ctl=%h want st=%0d ctl=%h", state_b, ctl_b, e.st, exp_ctl(e.st, 1'b1, e.rdy));
        end
      end
      @(negedge clk);
    end
  endtask

  task automatic do_reset();
    rst = 1'b0; run = 1'b0; mem_ready = 1'b0; opcode = 6'h00;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b0; run = 1'b1; mem_ready = 1'b1; opcode = 6'h23;
    repeat (2) begin
      @(negedge clk); #1;
      checks++;
      if (state_a !== 4'd0 || ctl_a !== 16'h0 || ctl_b !== 16'h0) begin
        errors++;
        $display("FAIL reset_low got st=%0d ctl_a=%h ctl_b=%h want st=0 ctl=0", state_a, ctl_a, ctl_b);
      end
    end
    @(negedge clk);
    rst = 1'b1; #1;
    checks++;
    if (ctl_a !== 16'h0 || icnt_a !== 32'd0 || ccnt_a !== 32'd0 || illegal_a !== 1'b0 || timeout_a !== 1'b0) begin
      errors++;
      $display("FAIL reset_after got ctl=%h icnt=%0d ccnt=%0d ill=%b to=%b want all 0", ctl_a, icnt_a, ccnt_a, illegal_a, timeout_a);
    end
    @(negedge clk); #1;
    checks++;
    if (state_a !== 4'd0 || ctl_a !== exp_ctl(4'd0, 1'b1, 1'b1)) begin
      errors++;
      $display("FAIL reset_first_fetch got st=%0d ctl=%h want st=0 ctl=%h", state_a, ctl_a, exp_ctl(4'd0, 1'b1, 1'b1));
    end
    @(negedge clk); #1;
    checks++;
    if (state_a !== 4'd1) begin
      errors++;
      $display("FAIL reset_decode got st=%0d want 1", state_a);
    end
  endtask

  task automatic test_lw();
    do_reset();
    push_instr(6'h23);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (state_a !== 4'd0 || icnt_a !== 32'd1 || ccnt_a !== 32'd5 || icnt_b !== 4'd1) begin
      errors++;
      $display("FAIL lw_counts got st=%0d icnt=%0d ccnt=%0d icnt_b=%0d want 0 1 5 1", state_a, icnt_a, ccnt_a, icnt_b);
    end
  endtask

  task automatic test_sw_wait();
    do_reset();
    push(4'd0, 6'h2B, 1'b1); push(4'd1, 6'h2B, 1'b1); push(4'd2, 6'h2B, 1'b1);
    repeat (3) push(4'd5, 6'h2B, 1'b0);
    push(4'd5, 6'h2B, 1'b1);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (state_a !== 4'd0 || timeout_a !== 1'b0 || icnt_a !== 32'd1) begin
      errors++;
      $display("FAIL sw_wait got st=%0d to=%b icnt=%0d want 0 0 1", state_a, timeout_a, icnt_a);
    end
  endtask

  task automatic test_timeout();
    do_reset();
    repeat (15) push(4'd0, 6'h00, 1'b0);
    drain(1'b1, 1'b1);
    mem_ready = 1'b1; #1;
    checks++;
    if (state_a !== 4'd15 || timeout_a !== 1'b1 || ctl_a !== 16'h0 || state_b !== 4'd15 || timeout_b !== 1'b1) begin
      errors++;
      $display("FAIL timeout_halt got st=%0d to=%b ctl=%h st_b=%0d want 15 1 0 15", state_a, timeout_a, ctl_a, state_b);
    end
    repeat (3) @(negedge clk);
    #1;
    checks++;
    if (state_a !== 4'd15 || ctl_a !== 16'h0 || ccnt_a !== 32'd15) begin
      errors++;
      $display("FAIL halt_hold got st=%0d ctl=%h ccnt=%0d want 15 0 15", state_a, ctl_a, ccnt_a);
    end
    rst = 1'b0;
    @(negedge clk); #1;
    checks++;
    if (state_a !== 4'd0 || timeout_a !== 1'b0 || illegal_a !== 1'b0) begin
      errors++;
      $display("FAIL halt_reset got st=%0d to=%b want 0 0", state_a, timeout_a);
    end
    // Ready on the last allowed wait cycle completes the fetch.
    do_reset();
    repeat (14) push(4'd0, 6'h02, 1'b0);
    push(4'd0, 6'h02, 1'b1); push(4'd1, 6'h02, 1'b1); push(4'd9, 6'h02, 1'b1);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (state_a !== 4'd0 || timeout_a !== 1'b0 || icnt_a !== 32'd1) begin
      errors++;
      $display("FAIL timeout_edge got st=%0d to=%b icnt=%0d want 0 0 1", state_a, timeout_a, icnt_a);
    end
  endtask

  task automatic test_illegal();
    do_reset();
    push(4'd0, 6'h3F, 1'b1); push(4'd1, 6'h3F, 1'b1);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (state_a !== 4'd0 || illegal_a !== 1'b1 || icnt_a !== 32'd0 || illegal_b !== 1'b1) begin
      errors++;
      $display("FAIL illegal_3f got st=%0d ill=%b icnt=%0d ill_b=%b want 0 1 0 1", state_a, illegal_a, icnt_a, illegal_b);
    end
    do_reset();
    push(4'd0, 6'h08, 1'b1); push(4'd1, 6'h08, 1'b1);
    drain(1'b0, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (state_b !== 4'd0 || illegal_b !== 1'b1 || icnt_b !== 4'd0) begin
      errors++;
      $display("FAIL illegal_addi got st=%0d ill=%b icnt=%0d want 0 1 0", state_b, illegal_b, icnt_b);
    end
    do_reset();
    push_instr(6'h08);
    drain(1'b1, 1'b0);
    run = 1'b0; #1;
    checks++;
    if (illegal_a !== 1'b0 || icnt_a !== 32'd1 || state_a !== 4'd0) begin
      errors++;
      $display("FAIL addi_ok got ill=%b icnt=%0d st=%0d want 0 1 0", illegal_a, icnt_a, state_a);
    end
  endtask

  task automatic test_back_to_back();
    do_reset();
    push_instr(6'h00); push_instr(6'h04); push_instr(6'h02);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (icnt_a !== 32'd3 || ccnt_a !== 32'd10 || state_a !== 4'd0) begin
      errors++;
      $display("FAIL b2b_counts got icnt=%0d ccnt=%0d st=%0d want 3 10 0", icnt_a, ccnt_a, state_a);
    end
  endtask

  task automatic test_wrap();
    do_reset();
    repeat (16) push_instr(6'h02);
    drain(1'b1, 1'b1);
    run = 1'b0; #1;
    checks++;
    if (icnt_a !== 32'd16 || ccnt_a !== 32'd48 || icnt_b !== 4'd0 || ccnt_b !== 4'd0) begin
      errors++;
      $display("FAIL wrap got icnt=%0d ccnt=%0d icnt_b=%0d ccnt_b=%0d want 16 48 0 0", icnt_a, ccnt_a, icnt_b, ccnt_b);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    push(4'd0, 6'h23, 1'b1); push(4'd1, 6'h23, 1'b1); push(4'd2, 6'h23, 1'b1);
    push(4'd3, 6'h23, 1'b0);
    drain(1'b1, 1'b1);
    rst = 1'b0; #1;
    checks++;
    if (state_a !== 4'd3 || ctl_a !== 16'h0 || ctl_b !== 16'h0) begin
      errors++;
      $display("FAIL reset_mid_low got st=%0d ctl=%h ctl_b=%h want 3 0 0", state_a, ctl_a, ctl_b);
    end
    @(negedge clk); #1;
    checks++;
    if (state_a !== 4'd0 || ctl_a[15] !== 1'b0 || state_b !== 4'd0) begin
      errors++;
      $display("FAIL reset_mid got st=%0d mem_req=%b st_b=%0d want 0 0 0", state_a, ctl_a[15], state_b);
    end
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_lw();
    test_sw_wait();
    test_timeout();
    test_illegal();
    test_back_to_back();
    test_wrap();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mc_cpu_ctrl.md
Name: mc_cpu_ctrl

Overview:
Multi-cycle control sequencer for the next-generation 32-bit MIPS core. It replaces the single-cycle decode-and-go control path with a clocked FSM that steps each instruction through fetch, decode, execute, memory and writeback over 3-5+ cycles. It also adds a memory ready handshake with timeout, an optional ADDI mode, sticky fault flags and performance counters. It sits between the instruction register opcode field and the shared datapath (PC, register file, ALU, unified memory).

Parameters:
CNT_W, 32, width of the instr_count and cycle_count performance counters
TIMEOUT, 15, maximum cycles to wait for mem_ready before faulting (legal range 1..255)
EN_ADDI, 1, 1 = opcode 0x08 (ADDI) is decoded; 0 = ADDI is treated as illegal

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-low reset
run  in  1  permits a new instruction fetch, sampled in S_FETCH only
opcode  in  6  instruction register bits [31:26]
mem_ready  in  1  memory has completed the current request in this cycle
mem_req  out  1  memory request valid
mem_we  out  1  request is a write (valid only with mem_req)
iord  out  1  memory address select: 0 = PC, 1 = ALUOut
ir_write  out  1  load the instruction register
pc_write  out  1  unconditional PC load
pc_write_cond  out  1  PC load if ALU zero (BEQ)
pc_src  out  2  PC source: 0 = ALU result, 1 = ALUOut, 2 = jump target
alu_src_a  out  1  ALU operand A: 0 = PC, 1 = rs
alu_src_b  out  2  ALU operand B: 0 = rt, 1 = constant 4, 2 = sign-extended immediate, 3 = sign-extended immediate << 2
alu_op  out  2  0 = add, 1 = subtract, 2 = use funct field
reg_dst  out  1  destination register: 0 = rt, 1 = rd
reg_write  out  1  register file write enable
mem_to_reg  out  1  writeback source: 0 = ALUOut, 1 = MDR
state  out  4  current state encoding, for debug
illegal  out  1  sticky flag: an unknown opcode was decoded
timeout  out  1  sticky flag: a memory wait expired
instr_count  out  CNT_W  number of retired instructions
cycle_count  out  CNT_W  number of cycles with run=1 and not in S_HALT

Behaviour:
- Reset: when reset=0 at a clock edge, the FSM goes to S_FETCH (0). All counters, flags and the wait counter clear. All control outputs are 0 while reset is low and in the cycle after it.
- Control outputs are Moore outputs, decoded from state only. The exceptions are ir_write and pc_write in S_FETCH, which are also gated by mem_ready.
- State encodings: FETCH 0, DECODE 1, MEMADR 2, MEMRD 3, MEMWB 4, MEMWR 5, EXEC 6, ALUWB 7, BRANCH 8, JUMP 9, ADDIEX 10, ADDIWB 11, HALT 15.
- S_FETCH, run=0: stay in S_FETCH with no request.
- S_FETCH, run=1: mem_req=1, iord=0, alu_src_a=0, alu_src_b=1, alu_op=0, pc_src=0.
  - When mem_ready=1: ir_write=1 and pc_write=1 in the same cycle, then go to S_DECODE.
- S_DECODE: alu_src_a=0, alu_src_b=3, alu_op=0. Next state by opcode:
  - 0x23 or 0x2B -> MEMADR
  - 0x00 -> EXEC
  - 0x04 -> BRANCH
  - 0x02 -> JUMP
  - 0x08 -> ADDIEX if EN_ADDI=1
  - any other opcode -> set illegal, go to FETCH; the instruction does not retire.
- S_MEMADR: alu_src_a=1, alu_src_b=2, alu_op=0. Go to MEMRD if opcode is 0x23, else MEMWR.
- S_MEMRD: mem_req=1, iord=1. When mem_ready=1, go to MEMWB.
- S_MEMWB: reg_write=1, mem_to_reg=1, reg_dst=0. Go to FETCH.
- S_MEMWR: mem_req=1, mem_we=1, iord=1. When mem_ready=1, go to FETCH.
- S_EXEC: alu_src_a=1, alu_src_b=0, alu_op=2. Go to ALUWB.
- S_ALUWB: reg_write=1, reg_dst=1, mem_to_reg=0. Go to FETCH.
- S_BRANCH: alu_src_a=1, alu_src_b=0, alu_op=1, pc_write_cond=1, pc_src=1. Go to FETCH.
- S_JUMP: pc_write=1, pc_src=2. Go to FETCH.
- S_ADDIEX: alu_src_a=1, alu_src_b=2, alu_op=0. Go to ADDIWB.
- S_ADDIWB: reg_write=1, reg_dst=0, mem_to_reg=0. Go to FETCH.
- Instruction latency (FETCH with zero wait states through retirement):
  - LW: 5 cycles
  - SW, R-type, ADDI: 4 cycles
  - BEQ, J: 3 cycles
- Wait counter:
  - Increments each cycle that mem_req=1 and mem_ready=0.
  - Clears on mem_ready=1 or on any state change.
  - If it reaches TIMEOUT while mem_ready is still 0: set timeout and go to S_HALT.
  - A mem_ready arriving in the same cycle the count reaches TIMEOUT wins: the access completes and there is no fault.
- S_HALT: all control outputs are 0. Only reset exits this state.
- instr_count increments by 1 in the cycle the FSM leaves MEMWB, MEMWR, ALUWB, BRANCH, JUMP or ADDIWB for FETCH.
- Both counters wrap modulo 2^CNT_W with no saturation.
- illegal and timeout are sticky; only reset clears them.
- run is ignored outside S_FETCH: an in-flight instruction always completes.

Test Plan:
- Reset, then run=1, opcode=0x23, mem_ready held at 1 -> state sequence 0,1,2,3,4,0. reg_write=1 and mem_to_reg=1 only in state 4. instr_count=1 after 5 cycles.
- opcode=0x2B with mem_ready=0 for 3 cycles in MEMWR, then 1 -> mem_req=mem_we=iord=1 held for 4 cycles, then FETCH. timeout=0.
- TIMEOUT=15, mem_ready stuck at 0 in FETCH -> timeout=1 and state=15 after 15 wait cycles. Outputs stay 0 until reset=0, then state=0 and flags clear.
- opcode=0x3F, then opcode=0x08 with EN_ADDI=0 -> illegal=1 after DECODE, return to FETCH, instr_count unchanged.
- R-type, BEQ, J back-to-back with zero wait states -> 4+3+3 = 10 cycles, instr_count=3. pc_write_cond=1 only in state 8; pc_src=2 in state 9.
- CNT_W=4, 16 J instructions -> instr_count wraps to 0. reset=0 asserted mid-MEMRD -> state=0 and mem_req=0 on the next edge.
